lapido_muldiv: RTL



---
 rtl/lapido_muldiv.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lapido_muldiv.sv
// lapido_muldiv: iterative multiply/divide responder for the lapido core.
//
// Accepts one request over a valid/ready channel, computes MUL/MULH (radix-2
// shift-add on magnitudes) or DIV/REM (restoring division on magnitudes) over
// WIDTH cycles, applies sign correction, then holds the result on a
// valid/ready response channel until it is taken.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_ready high only in IDLE
//   req_op               00 MUL, 01 MULH, 10 DIV, 11 REM
//   op1, op2             signed operands
//   resp_valid/ready     response handshake; resp_valid high only in DONE
//   resp_res             registered result
//   resp_flags           registered flags {NEGZERO, OVERFLOW, NEG, TRUE, ZERO}
//
// Build option: LAPIDO_MULDIV_DIV_EN
//   defined   - restoring divider and divide special cases are built.
//   undefined - no divider; DIV/REM return 0 with ZERO|NEGZERO|OVERFLOW
//               after one cycle.
//
// WIDTH must be even and at least 4.

module lapido_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_res,
    output logic [4:0]       resp_flags
);

    localparam int unsigned CW          = $clog2(WIDTH);
    localparam int unsigned FL_ZERO     = 0;
    localparam int unsigned FL_TRUE     = 1;
    localparam int unsigned FL_NEG      = 2;
    localparam int unsigned FL_OVERFLOW = 3;
    localparam int unsigned FL_NEGZERO  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [1:0]         op_q,      op_d;
    logic               sign1_q,   sign1_d;
    logic               sign2_q,   sign2_d;
    logic               special_q, special_d;
    // Multiplicand magnitude for MUL/MULH, divisor magnitude for DIV/REM.
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    // MUL: {partial product, remaining multiplier bits}.
    // DIV: {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   res_q,     res_d;
    logic [4:0]         flags_q,   flags_d;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_fix;
    logic               ovf_fix;
    logic               zero_fix;
`ifdef LAPIDO_MULDIV_DIV_EN
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   min_val;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_res   = res_q;
    assign resp_flags = flags_q;

    always_comb begin
        mag1    = op1[WIDTH-1] ? -op1 : op1;
        mag2    = op2[WIDTH-1] ? -op2 : op2;

        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        prod    = (sign1_q ^ sign2_q) ? -acc_q : acc_q;

`ifdef LAPIDO_MULDIV_DIV_EN
        min_val   = {1'b1, {(WIDTH-1){1'b0}}};
        // Shift the next dividend bit into the remainder and trial-subtract.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        quot      = (sign1_q ^ sign2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sign1_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

        // Result selection; special cases carry their result in acc low half.
        res_fix = '0;
        ovf_fix = 1'b0;
        if (special_q) begin
            res_fix = acc_q[WIDTH-1:0];
            ovf_fix = 1'b1;
        end else begin
            case (op_q)
                2'b00: begin
                    res_fix = prod[WIDTH-1:0];
                    ovf_fix = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
                end
                2'b01: res_fix = prod[2*WIDTH-1:WIDTH];
`ifdef LAPIDO_MULDIV_DIV_EN
                2'b10: res_fix = quot;
                2'b11: res_fix = rem;
`endif
                default: res_fix = '0;
            endcase
        end
        zero_fix = (res_fix == '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        special_d = special_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        res_d     = res_q;
        flags_d   = flags_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    sign1_d   = op1[WIDTH-1];
                    sign2_d   = op2[WIDTH-1];
                    special_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_ITER;
                    if (req_op[1]) begin
`ifdef LAPIDO_MULDIV_DIV_EN
                        opnd_d = mag2;
                        acc_d  = {{WIDTH{1'b0}}, mag1};
                        if (op2 == '0) begin
                            special_d = 1'b1;
                            acc_d     = {{WIDTH{1'b0}}, (req_op[0] ? op1 : {WIDTH{1'b1}})};
                            state_d   = S_FIX;
                        end else if ((op1 == min_val) && (op2 == '1)) begin
                            special_d = 1'b1;
                            acc_d     = {{WIDTH{1'b0}}, (req_op[0] ? {WIDTH{1'b0}} : min_val)};
                            state_d   = S_FIX;
                        end
`else
                        special_d = 1'b1;
                        acc_d     = '0;
                        state_d   = S_FIX;
`endif
                    end else begin
                        opnd_d = mag1;
                        acc_d  = {{WIDTH{1'b0}}, mag2};
                    end
                end
            end

            S_ITER: begin
                cnt_d = cnt_q + CW'(1);
`ifdef LAPIDO_MULDIV_DIV_EN
                if (op_q[1]) begin
                    if (!div_trial[WIDTH]) begin
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                res_d                = res_fix;
                flags_d              = '0;
                flags_d[FL_ZERO]     = zero_fix;
                flags_d[FL_TRUE]     = ~zero_fix;
                flags_d[FL_NEG]      = res_fix[WIDTH-1];
                flags_d[FL_OVERFLOW] = ovf_fix;
                flags_d[FL_NEGZERO]  = res_fix[WIDTH-1] | zero_fix;
                state_d              = S_DONE;
            end

            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            special_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            special_q <= special_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
        end
    end

endmodule
